// File: rtl/line_mem_responder.sv
// Line memory with a req/ack single-line access port and a valid/ready full-array dump port.
// Define PARITY_EN to store an even-parity bit per line and flag mismatches on read and dump.
module line_mem_responder #(
    parameter int LINE_W = 25,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wdata,
    output logic              ack,
    output logic              rvalid,
    output logic [LINE_W-1:0] rdata,
    output logic              busy,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [LINE_W-1:0] dump_data,
    output logic              dump_done,
    output logic              parity_err
);

`ifdef PARITY_EN
    localparam int MEM_W = LINE_W + 1;
`else
    localparam int MEM_W = LINE_W;
`endif

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DUMP, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [MEM_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [MEM_W-1:0]  wentry;
    logic              addr_ok;
    logic              dump_pend;
    logic              dump_go;
    logic              rd_perr;
    logic              dump_perr;

    assign addr_ok = (int'(addr_q) < DEPTH);
    // A pending dump only starts when no access request competes for the same IDLE cycle.
    assign dump_go = (state == S_IDLE) && !req && dump_pend;

`ifdef PARITY_EN
    assign wentry    = {^wdata_q, wdata_q};
    assign dump_perr = dump_valid && (^mem[dump_addr]);
`else
    assign wentry    = wdata_q;
    assign dump_perr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req)            state_nxt = we ? S_WR : S_RD;
                else if (dump_pend) state_nxt = S_DUMP;
            end
            S_RD, S_WR: state_nxt = S_IDLE;
            S_DUMP:     if (dump_ready && dump_addr == LAST_ADDR) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        dump_valid = (state == S_DUMP);
        dump_done  = (state == S_DONE);
        dump_data  = dump_valid ? mem[dump_addr][LINE_W-1:0] : '0;
        parity_err = rd_perr | dump_perr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            ack       <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rd_perr   <= 1'b0;
            dump_pend <= 1'b0;
            dump_addr <= '0;
        end else begin
            ack     <= 1'b0;
            rvalid  <= 1'b0;
            rd_perr <= 1'b0;
            if (state == S_IDLE && req) begin
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (dump_go) begin
                dump_pend <= 1'b0;
                dump_addr <= '0;
            end
            if (dump_start && state != S_DUMP) dump_pend <= 1'b1;
            if (state == S_DUMP && dump_ready && dump_addr != LAST_ADDR)
                dump_addr <= dump_addr + 1'b1;
            if (state == S_RD) begin
                ack     <= 1'b1;
                rvalid  <= 1'b1;
                rdata   <= addr_ok ? mem[addr_q][LINE_W-1:0] : '0;
`ifdef PARITY_EN
                rd_perr <= addr_ok && (^mem[addr_q]);
`endif
            end
            if (state == S_WR) ack <= 1'b1;
        end
    end

    // Array has no reset; an aborted write never reaches S_WR's commit edge.
    always_ff @(posedge clk) begin
        if (state == S_WR && addr_ok) mem[addr_q] <= wentry;
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Randomized self-checking bench for line_mem_responder against an array-based reference.
// Define PARITY_EN on both files to exercise the parity path.
module tb_line_mem_responder;
    localparam int LINE_W = 25;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req = 1'b0, we = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [LINE_W-1:0] wdata = '0;
    logic              ack, rvalid, busy, dump_valid, dump_done, parity_err;
    logic [LINE_W-1:0] rdata, dump_data;
    logic [ADDR_W-1:0] dump_addr;
    logic              dump_start = 1'b0, dump_ready = 1'b0;

    logic [LINE_W-1:0] model_mem [DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    line_mem_responder #(.LINE_W(LINE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rvalid(rvalid), .rdata(rdata), .busy(busy),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access; ack is expected exactly two edges after req is first sampled.
    task automatic access(input bit w, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                          input bit exp_perr, input string tag);
        int n = 0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        do begin step(); n++; end while (!ack && n < 50);
        req = 1'b0;
        check({tag, "_ack"}, ack, 1);
        check({tag, "_lat"}, n, 2);
        check({tag, "_rvalid"}, rvalid, !w);
        check({tag, "_perr"}, parity_err, exp_perr);
        if (w) model_mem[a] = d;
        else   check({tag, "_rdata"}, rdata, model_mem[a]);
        step();
        check({tag, "_ack_pulse"}, ack, 0);
        check({tag, "_rvalid_pulse"}, rvalid, 0);
        if (!w) check({tag, "_rdata_hold"}, rdata, model_mem[a]);
    endtask

    task automatic pulse_dump_start();
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
    endtask

    // Drain a dump; mode 0 always ready, 1 toggling, 2 random. Called at #1 after an edge.
    task automatic run_dump(input int mode, input bit no_ack, input string tag);
        int exp_a = 0, guard = 0, cyc = 0, done_cnt = 0;
        bit rdy;
        while (!dump_valid && guard < 20) begin step(); guard++; end
        check({tag, "_valid"}, dump_valid, 1);
        while (exp_a < DEPTH && guard < 2000) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            dump_ready = rdy;
            check({tag, "_beat_valid"}, dump_valid, 1);
            check({tag, "_beat_addr"}, dump_addr, exp_a);
            check({tag, "_beat_data"}, dump_data, model_mem[exp_a]);
            check({tag, "_beat_perr"}, parity_err, 0);
            if (no_ack) check({tag, "_no_ack"}, ack, 0);
            step();
            if (rdy) exp_a++;
            cyc++; guard++;
        end
        dump_ready = 1'b0;
        check({tag, "_beats"}, exp_a, DEPTH);
        if (dump_done) done_cnt++;
        check({tag, "_done_valid"}, dump_valid, 0);
        step();
        if (dump_done) done_cnt++;
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", ack, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_dump_done", dump_done, 0);
        check("rst_dump_addr", dump_addr, 0);
        check("rst_perr", parity_err, 0);
        @(negedge clk);
        rst = 1'b1;

        access(1, 6'd5, 25'h1ABCDEF, 0, "wr5");
        access(0, 6'd5, 25'h0, 0, "rd5");

        // Back-to-back writes with req held high through each ack cycle.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 6'd0; wdata = 25'd1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin step(); n++; end while (!ack && n < 20);
            check("b2b_ack", ack, 1);
            check("b2b_spacing", n, 2);
            model_mem[i] = LINE_W'(i + 1);
            if (i < 3) begin
                addr = ADDR_W'(i + 1);
                wdata = LINE_W'(i + 2);
            end else req = 1'b0;
        end
        for (int i = 0; i < 4; i++) access(0, ADDR_W'(i), '0, 0, "b2b_rd");

        for (int i = 0; i < DEPTH; i++) access(1, ADDR_W'(i), LINE_W'(i), 0, "fill");
        step();
        pulse_dump_start();
        run_dump(1, 0, "dump_bp");

        // Read request and dump_start in the same cycle: read wins, dump follows.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 6'd7; dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        step();
        req = 1'b0;
        check("prio_ack", ack, 1);
        check("prio_rvalid", rvalid, 1);
        check("prio_rdata", rdata, model_mem[7]);
        check("prio_no_dump_yet", dump_valid, 0);
        run_dump(0, 0, "prio_dump");

        // Request raised mid-dump stays pending until the dump completes.
        pulse_dump_start();
        step();
        check("middump_valid", dump_valid, 1);
        req = 1'b1; we = 1'b0; addr = 6'd7;
        run_dump(2, 1, "middump");
        n = 0;
        while (!ack && n < 10) begin step(); n++; end
        req = 1'b0;
        check("middump_ack", ack, 1);
        check("middump_rdata", rdata, model_mem[7]);
        step();

        for (int i = 0; i < 80; i++) begin
            logic [ADDR_W-1:0] ra;
            ra = ADDR_W'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 99) < 50) access(1, ra, LINE_W'($urandom), 0, "rnd_wr");
            else                            access(0, ra, '0, 0, "rnd_rd");
        end
        step();
        pulse_dump_start();
        run_dump(2, 0, "rnd_dump");

        // Asynchronous reset at beat 10 of a dump.
        pulse_dump_start();
        dump_ready = 1'b1;
        n = 0;
        while (!(dump_valid && dump_addr == 6'd10) && n < 100) begin step(); n++; end
        check("rstdump_beat10", dump_addr, 10);
        #2;
        rst = 1'b0;
        #1;
        check("rstdump_valid", dump_valid, 0);
        check("rstdump_busy", busy, 0);
        check("rstdump_ack", ack, 0);
        check("rstdump_done", dump_done, 0);
        dump_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) step();
        check("rstdump_no_resume", dump_valid, 0);
        check("rstdump_idle", busy, 0);
        access(1, 6'd2, 25'h0155AA3, 0, "post_rst_wr2");
        access(0, 6'd2, '0, 0, "post_rst_rd2");

`ifdef PARITY_EN
        access(1, 6'd9, 25'h0000001, 0, "par_wr9");
        @(negedge clk);
        dut.mem[9][LINE_W] = ~dut.mem[9][LINE_W];
        access(0, 6'd9, '0, 1, "par_rd9_bad");
        access(1, 6'd9, 25'h0000001, 0, "par_rewr9");
        access(0, 6'd9, '0, 0, "par_rd9_good");
        access(0, 6'd5, '0, 0, "par_rd_clean");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want end of test");
        $fatal(1, "watchdog");
    end
endmodule
